buzzer_pattern_decoder: RTL
===========================

Name: buzzer_pattern_decoder

Overview:
- Receive-side counterpart of the alert buzzer driver. Listens to a 2 kHz-tone beep line (the buzzer drive or a sensor comparator), recovers the group envelope, and reconstructs the 2-bit alert code (01 hot, 10 cold, 00 none).
- Sits in the test/monitor path to close the loop on the alert output. Used for self-test and remote annunciation.

Parameters:
- TONE_TO, 50_000, cycles without a tone rising edge before the tone counts as absent (1 ms @ 50 MHz)
- GAP_MIN, 5_000_000, silences shorter than this are intra-burst and ignored (100 ms)
- COLD_MIN, 10_000_000, lower bound of the cold inter-group silence (200 ms)
- COLD_MAX, 15_000_000, upper bound of the cold silence (300 ms)
- HOT_MIN, 40_000_000, lower bound of the hot inter-group silence (0.8 s)
- HOT_MAX, 60_000_000, upper bound of the hot silence (1.2 s)
- IDLE_TO, 100_000_000, silence that forces code 00 (2 s)
- CONFIRM, 2, consecutive matching classifications required before the code changes
- CW, 27, counter width; must satisfy 2^CW > IDLE_TO

Ports:
- clk  in  1  system clock, 50 MHz
- rst_n  in  1  reset, asynchronous, active-low
- tone_in  in  1  asynchronous beep line
- tone_det  out  1  tone currently present
- codigo  out  2  decoded alert: 00 none, 01 hot, 10 cold; 11 is never driven
- code_valid  out  1  one-cycle pulse when codigo changes value

Behaviour:
- Reset values:
  - codigo=00, tone_det=0, code_valid=0.
  - State IDLE; all counters and the synchronizer cleared; cand=00, match=0.
- Input conditioning:
  - 2-FF synchronizer on tone_in, then rising-edge detect.
  - tone_cnt clears on each edge and otherwise increments, saturating at TONE_TO.
  - tone_det=1 iff an edge has been seen since reset and tone_cnt<TONE_TO. This is a registered output, 3 cycles after the first input edge.
- State machine, states IDLE / TONE / GAP:
  - IDLE -> TONE when tone_det rises.
  - TONE -> GAP when tone_det falls; gap_cnt<=0.
  - GAP:
    - gap_cnt increments each cycle.
    - GAP -> TONE when tone_det rises; gap_cnt is classified on that cycle.
    - GAP -> IDLE when gap_cnt reaches IDLE_TO.
- Classification of gap_cnt (g), all bounds inclusive:
  - g<GAP_MIN: ignore; cand and match are unchanged.
  - COLD_MIN<=g<=COLD_MAX: new candidate 10.
  - HOT_MIN<=g<=HOT_MAX: new candidate 01.
  - Any other value: invalid; match<=0, cand<=00, codigo held.
- Match logic:
  - If the new candidate == cand, match increments, saturating at CONFIRM.
  - Otherwise cand<=new candidate and match<=1.
  - When match reaches CONFIRM and cand!=codigo: codigo<=cand and code_valid pulses on the same cycle. Latency is 1 cycle after the classifying edge.
- Idle timeout: on GAP -> IDLE, codigo<=00, cand<=00, match<=0. code_valid pulses only if codigo was non-zero.
- Simultaneous events:
  - gap_cnt==IDLE_TO on the same cycle tone_det rises: the timeout wins. The FSM goes to IDLE, then to TONE on the next cycle with no classification.
  - A tone that never stops: no classification occurs and codigo holds.
- Counters saturate; they never wrap.
- Reset mid-pattern: everything returns to reset values immediately. The first gap after reset is measured fresh.
- The first gap measured from IDLE is never classified. Only GAP -> TONE classifies.

Decomposition:
- buzzer_pkg holds:
  - Code constants CODE_NONE=2'b00, CODE_HOT=2'b01, CODE_COLD=2'b10.
  - Default timing constants, shared with the buzzer driver so both ends agree on periods.
- Sub-module tone_detector contains the synchronizer, edge detect, tone_cnt and tone_det. It is parameterized by TONE_TO and reused by other sensor inputs.
- The FSM, classifier and match logic stay in the top.

Test Plan (sim overrides):
- Override values: TONE_TO=20, GAP_MIN=100, COLD_MIN=200, COLD_MAX=300, HOT_MIN=800, HOT_MAX=1200, IDLE_TO=2000, CONFIRM=2.
- Tone stimulus is a 10-cycle-period square wave.

- Reset check: tone_in toggling while rst_n=0 -> codigo=00, tone_det=0, code_valid=0. After release, tone_det=1 within 3 cycles of the first edge.
- Cold pattern: tone bursts separated by 250-cycle silences -> codigo=10 with one code_valid pulse after the 2nd gap; no pulse on the 3rd gap.
- Hot pattern: 1000-cycle silences, including 50-cycle intra-burst gaps -> intra-burst gaps ignored; codigo=01 after 2 long gaps.
- Change and bounds: hot then cold -> codigo goes 01 to 10 after 2 cold gaps. A gap of exactly 200 or 300 classifies as cold; a gap of 199 or 500 clears match and codigo holds.
- Idle timeout: with codigo=01, silence of 2000 cycles -> codigo=00 and one code_valid pulse. Tone arriving at exactly the timeout cycle -> IDLE, no classification.
- Mid-pattern reset: assert rst_n after one cold gap -> outputs cleared. After release, a single cold gap does not set codigo.

Source files
------------

// File: rtl/buzzer_pattern_decoder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : buzzer_pkg
// Description : Alert codes, gap classes, decoder states and the default
//               timing shared by the buzzer driver and the pattern decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package buzzer_pkg;

   typedef logic [1:0] code_t;

   localparam code_t CODE_NONE = 2'b00;
   localparam code_t CODE_HOT  = 2'b01;
   localparam code_t CODE_COLD = 2'b10;

   // Periods at 50 MHz; the driver derives its beep groups from the same values
   localparam int unsigned DEF_TONE_TO  = 50_000;
   localparam int unsigned DEF_GAP_MIN  = 5_000_000;
   localparam int unsigned DEF_COLD_MIN = 10_000_000;
   localparam int unsigned DEF_COLD_MAX = 15_000_000;
   localparam int unsigned DEF_HOT_MIN  = 40_000_000;
   localparam int unsigned DEF_HOT_MAX  = 60_000_000;
   localparam int unsigned DEF_IDLE_TO  = 100_000_000;
   localparam int unsigned DEF_CONFIRM  = 2;
   localparam int          DEF_CW       = 27;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_TONE = 2'd1,
      ST_GAP  = 2'd2
   } dec_state_t;

   typedef enum logic [1:0] {
      CLS_IGNORE  = 2'd0,
      CLS_COLD    = 2'd1,
      CLS_HOT     = 2'd2,
      CLS_INVALID = 2'd3
   } gap_class_t;

   function automatic gap_class_t classify_gap(
      input logic [31:0] g,
      input logic [31:0] gap_min,
      input logic [31:0] cold_min,
      input logic [31:0] cold_max,
      input logic [31:0] hot_min,
      input logic [31:0] hot_max
   );
      gap_class_t cls;
      if (g < gap_min)
         cls = CLS_IGNORE;
      else if (g >= cold_min && g <= cold_max)
         cls = CLS_COLD;
      else if (g >= hot_min && g <= hot_max)
         cls = CLS_HOT;
      else
         cls = CLS_INVALID;
      return cls;
   endfunction

endpackage
`default_nettype wire

// File: rtl/buzzer_pattern_decoder_if.sv
`default_nettype none
// ============================================================================
// Module      : buzzer_pattern_decoder_if
// Description : Beep line in, tone/alert-code status out.
// Revision    : 1.0 - initial release
// ============================================================================
interface buzzer_pattern_decoder_if;
   import buzzer_pkg::*;

   logic  tone_in;
   logic  tone_det;
   code_t codigo;
   logic  code_valid;

   modport master (output tone_in, input tone_det, input codigo, input code_valid);
   modport slave  (input tone_in, output tone_det, output codigo, output code_valid);
endinterface
`default_nettype wire

// File: rtl/buzzer_pattern_decoder_tone_detector.sv
`default_nettype none
// ============================================================================
// Module      : tone_detector
// Description : Synchronises a beep line and flags a tone while rising edges
//               keep arriving within TONE_TO cycles of each other.
// Revision    : 1.0 - initial release
// ============================================================================
module tone_detector
   import buzzer_pkg::*;
#(
   parameter int unsigned TONE_TO = DEF_TONE_TO
)(
   input  logic clk,
   input  logic rst_n,
   input  logic tone_in,
   output logic tone_det
);

   localparam int TW = $clog2(TONE_TO + 1);
   localparam logic [TW-1:0] C_TONE_TO = TW'(TONE_TO);

   logic          r_sync1;
   logic          r_sync2;
   logic          r_sync3;
   logic          r_seen;
   logic [TW-1:0] r_tone_cnt;
   logic          w_edge;
   logic          w_seen_nxt;
   logic [TW-1:0] w_cnt_nxt;

   assign w_edge     = r_sync2 & ~r_sync3;
   assign w_seen_nxt = r_seen | w_edge;

   always_comb begin
      w_cnt_nxt = r_tone_cnt;
      if (w_edge)
         w_cnt_nxt = '0;
      else if (r_tone_cnt < C_TONE_TO)
         w_cnt_nxt = r_tone_cnt + TW'(1);
   end

   // tone_det is computed from next-state values so it rises the cycle after the edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1    <= 1'b0;
         r_sync2    <= 1'b0;
         r_sync3    <= 1'b0;
         r_seen     <= 1'b0;
         r_tone_cnt <= '0;
         tone_det   <= 1'b0;
      end else begin
         r_sync1    <= tone_in;
         r_sync2    <= r_sync1;
         r_sync3    <= r_sync2;
         r_seen     <= w_seen_nxt;
         r_tone_cnt <= w_cnt_nxt;
         tone_det   <= w_seen_nxt && (w_cnt_nxt < C_TONE_TO);
      end
   end

endmodule
`default_nettype wire

// File: rtl/buzzer_pattern_decoder.sv
`default_nettype none
// ============================================================================
// Module      : buzzer_pattern_decoder
// Description : Measures silences between beep groups and recovers the
//               2-bit alert code after CONFIRM matching classifications.
// Revision    : 1.0 - initial release
// ============================================================================
module buzzer_pattern_decoder
   import buzzer_pkg::*;
#(
   parameter int unsigned TONE_TO  = DEF_TONE_TO,
   parameter int unsigned GAP_MIN  = DEF_GAP_MIN,
   parameter int unsigned COLD_MIN = DEF_COLD_MIN,
   parameter int unsigned COLD_MAX = DEF_COLD_MAX,
   parameter int unsigned HOT_MIN  = DEF_HOT_MIN,
   parameter int unsigned HOT_MAX  = DEF_HOT_MAX,
   parameter int unsigned IDLE_TO  = DEF_IDLE_TO,
   parameter int unsigned CONFIRM  = DEF_CONFIRM,
   parameter int          CW       = DEF_CW
)(
   input  logic                     clk,
   input  logic                     rst_n,
   buzzer_pattern_decoder_if.slave  bus
);

   localparam int MW = $clog2(CONFIRM + 1);
   localparam logic [CW-1:0] C_IDLE_TO = CW'(IDLE_TO);
   localparam logic [MW-1:0] C_CONFIRM = MW'(CONFIRM);

   dec_state_t    r_state;
   dec_state_t    w_state_nxt;
   logic [CW-1:0] r_gap_cnt;
   logic [CW-1:0] w_gap_cnt_nxt;
   logic          w_classify;
   logic          w_timeout;
   gap_class_t    w_class;
   code_t         w_new_cand;
   code_t         r_cand;
   logic [MW-1:0] r_match;
   code_t         r_codigo;
   logic          r_code_valid;
   logic          w_tone_det;

   tone_detector #(
      .TONE_TO (TONE_TO)
   ) u_tone_detector (
      .clk      (clk),
      .rst_n    (rst_n),
      .tone_in  (bus.tone_in),
      .tone_det (w_tone_det)
   );

   assign bus.tone_det   = w_tone_det;
   assign bus.codigo     = r_codigo;
   assign bus.code_valid = r_code_valid;

   assign w_class    = classify_gap(32'(r_gap_cnt), GAP_MIN, COLD_MIN, COLD_MAX, HOT_MIN, HOT_MAX);
   assign w_new_cand = (w_class == CLS_HOT) ? CODE_HOT : CODE_COLD;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_gap_cnt <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_gap_cnt <= w_gap_cnt_nxt;
      end
   end

   // Timeout is tested before the returning tone so a tie goes to IDLE unclassified
   always_comb begin
      w_state_nxt   = r_state;
      w_gap_cnt_nxt = r_gap_cnt;
      w_classify    = 1'b0;
      w_timeout     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_tone_det)
               w_state_nxt = ST_TONE;
         end
         ST_TONE: begin
            if (!w_tone_det) begin
               w_state_nxt   = ST_GAP;
               w_gap_cnt_nxt = '0;
            end
         end
         ST_GAP: begin
            if (r_gap_cnt >= C_IDLE_TO) begin
               w_timeout   = 1'b1;
               w_state_nxt = ST_IDLE;
            end else if (w_tone_det) begin
               w_classify  = 1'b1;
               w_state_nxt = ST_TONE;
            end else begin
               w_gap_cnt_nxt = r_gap_cnt + CW'(1);
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cand       <= CODE_NONE;
         r_match      <= '0;
         r_codigo     <= CODE_NONE;
         r_code_valid <= 1'b0;
      end else begin
         r_code_valid <= 1'b0;
         if (w_timeout) begin
            r_cand       <= CODE_NONE;
            r_match      <= '0;
            r_codigo     <= CODE_NONE;
            r_code_valid <= (r_codigo != CODE_NONE);
         end else begin
            if (w_classify) begin
               case (w_class)
                  CLS_COLD, CLS_HOT: begin
                     if (w_new_cand == r_cand) begin
                        if (r_match < C_CONFIRM)
                           r_match <= r_match + MW'(1);
                     end else begin
                        r_cand  <= w_new_cand;
                        r_match <= MW'(1);
                     end
                  end
                  CLS_INVALID: begin
                     r_cand  <= CODE_NONE;
                     r_match <= '0;
                  end
                  default: ;
               endcase
            end
            if (r_match == C_CONFIRM && r_cand != r_codigo) begin
               r_codigo     <= r_cand;
               r_code_valid <= 1'b1;
            end
         end
      end
   end

endmodule
`default_nettype wire
